rr_arbiter4: RTL and testbench



---
 rtl/rr_arbiter4_if.sv | 21 ++
 rtl/rr_arbiter4.sv | 133 +++++++++++++
 tb/tb_rr_arbiter4.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
interface rr_arbiter4_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot/binary grant and a
// hold limit after which a waiting requester preempts the current owner.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter4_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Preemption fires once hold_cnt reaches MAX_HOLD-1, i.e. after MAX_HOLD granted cycles.
    localparam bit         HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LIM = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hold_cnt;
    logic [3:0] grant_r;
    logic [1:0] idx_r;
    logic       valid_r;

    logic [3:0] others;
    logic       owner_req;
    logic       release_now;
    logic       preempt_now;
    logic [1:0] next_ptr;
    logic [3:0] win_idle;
    logic [3:0] win_release;
    logic [3:0] win_preempt;

    function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [3:0] w;
        logic [1:0] j;
        w = 4'b0000;
        // Walk from the far end so the nearest requester to start overwrites last.
        for (int k = 3; k >= 0; k--) begin
            j = start + 2'(k);
            if (r[j]) begin
                w = 4'b0001 << j;
            end
        end
        return w;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        others      = bus.req & ~grant_r;
        owner_req   = bus.req[idx_r];
        next_ptr    = idx_r + 2'd1;
        release_now = !owner_req;
        preempt_now = HOLD_EN && owner_req && (hold_cnt >= HOLD_LIM) && (others != 4'b0000);
        win_idle    = rr_pick(bus.req, ptr);
        win_release = rr_pick(bus.req, next_ptr);
        win_preempt = rr_pick(others, next_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= 8'd0;
            grant_r  <= 4'b0000;
            idx_r    <= 2'd0;
            valid_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != 4'b0000) begin
                        state    <= GRANT;
                        grant_r  <= win_idle;
                        idx_r    <= onehot_to_idx(win_idle);
                        valid_r  <= 1'b1;
                        hold_cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr      <= next_ptr;
                        hold_cnt <= 8'd0;
                        if (bus.req != 4'b0000) begin
                            grant_r <= win_release;
                            idx_r   <= onehot_to_idx(win_release);
                            valid_r <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            grant_r <= 4'b0000;
                            idx_r   <= 2'd0;
                            valid_r <= 1'b0;
                        end
                    end else if (preempt_now) begin
                        ptr      <= next_ptr;
                        hold_cnt <= 8'd0;
                        grant_r  <= win_preempt;
                        idx_r    <= onehot_to_idx(win_preempt);
                        valid_r  <= 1'b1;
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_r <= 4'b0000;
                    idx_r   <= 2'd0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_idx   = idx_r;
    assign bus.grant_valid = valid_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two instances (hold limit 8 and unlimited) driven in
// lockstep against a cycle model through an expected-result queue.
module tb_rr_arbiter4;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] ptr;
        logic [7:0] hold;
    } model_t;

    logic clk;
    logic rst;

    rr_arbiter4_if bus8();
    rr_arbiter4_if bus0();

    rr_arbiter4 #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    rr_arbiter4 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int tests_run;
    int tests_failed;

    model_t     m8;
    model_t     m0;
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] scan(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (r[j]) return 4'(1 << j);
        end
        return 4'b0000;
    endfunction

    function automatic int owner_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    function automatic model_t step(input model_t m, input logic [3:0] r, input logic rs, input int mh);
        model_t n;
        int g;
        n = m;
        if (rs) begin
            n.grant = 4'b0000;
            n.ptr   = 2'd0;
            n.hold  = 8'd0;
        end else if (m.grant == 4'b0000) begin
            if (r != 4'b0000) begin
                n.grant = scan(r, int'(m.ptr));
                n.hold  = 8'd0;
            end
        end else begin
            g = owner_of(m.grant);
            if (!r[g]) begin
                n.ptr   = 2'((g + 1) % 4);
                n.grant = scan(r, (g + 1) % 4);
                n.hold  = 8'd0;
            end else if (mh != 0 && int'(m.hold) >= mh - 1 && (r & ~m.grant) != 4'b0000) begin
                n.ptr   = 2'((g + 1) % 4);
                n.grant = scan(r & ~m.grant, (g + 1) % 4);
                n.hold  = 8'd0;
            end else if (m.hold != 8'hFF) begin
                n.hold = m.hold + 8'd1;
            end
        end
        return n;
    endfunction

    // One clock: drive on the falling edge, queue the model's prediction, compare after the rising edge.
    task automatic cycle(input logic [3:0] r, input logic rs);
        logic [7:0] e;
        logic [3:0] e8;
        logic [3:0] e0;
        @(negedge clk);
        bus8.req = r;
        bus0.req = r;
        rst      = rs;
        m8 = step(m8, r, rs, 8);
        m0 = step(m0, r, rs, 0);
        exp_q.push_back({m8.grant, m0.grant});
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        e8 = e[7:4];
        e0 = e[3:0];
        tests_run++;
        if (bus8.grant !== e8) begin
            tests_failed++;
            $display("FAIL sb_grant_h8 t=%0t actual=%b expected=%b", $time, bus8.grant, e8);
        end
        tests_run++;
        if (bus8.grant_idx !== 2'(owner_of(e8))) begin
            tests_failed++;
            $display("FAIL sb_idx_h8 t=%0t actual=%b expected=%0d", $time, bus8.grant_idx, owner_of(e8));
        end
        tests_run++;
        if (bus8.grant_valid !== (e8 != 4'b0000)) begin
            tests_failed++;
            $display("FAIL sb_valid_h8 t=%0t actual=%b expected=%b", $time, bus8.grant_valid, e8 != 4'b0000);
        end
        tests_run++;
        if (bus0.grant !== e0) begin
            tests_failed++;
            $display("FAIL sb_grant_h0 t=%0t actual=%b expected=%b", $time, bus0.grant, e0);
        end
        tests_run++;
        if (bus0.grant_idx !== 2'(owner_of(e0)) || bus0.grant_valid !== (e0 != 4'b0000)) begin
            tests_failed++;
            $display("FAIL sb_idx_valid_h0 t=%0t actual=%b/%b expected=%0d/%b", $time,
                     bus0.grant_idx, bus0.grant_valid, owner_of(e0), e0 != 4'b0000);
        end
        tests_run++;
        if (!(bus8.grant == 4'b0000 || $onehot(bus8.grant)) || !(bus0.grant == 4'b0000 || $onehot(bus0.grant))) begin
            tests_failed++;
            $display("FAIL inv_onehot t=%0t actual=%b/%b required=zero_or_onehot", $time, bus8.grant, bus0.grant);
        end
        tests_run++;
        if (bus8.grant_valid !== (bus8.grant != 4'b0000) || bus0.grant_valid !== (bus0.grant != 4'b0000)) begin
            tests_failed++;
            $display("FAIL inv_valid t=%0t actual=%b/%b required=grant_nonzero", $time, bus8.grant_valid, bus0.grant_valid);
        end
        tests_run++;
        if (((bus8.grant | bus0.grant) & ~r) !== 4'b0000) begin
            tests_failed++;
            $display("FAIL inv_requested t=%0t actual=%b/%b required_subset_of=%b", $time, bus8.grant, bus0.grant, r);
        end
    endtask

    task automatic test_reset();
        cycle(4'b1111, 1'b1);
        cycle(4'b0000, 1'b1);
        tests_run++;
        if (bus8.grant !== 4'b0000 || bus8.grant_idx !== 2'd0 || bus8.grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state actual=%b/%b/%b required=0000/00/0", bus8.grant, bus8.grant_idx, bus8.grant_valid);
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_basic();
        cycle(4'b0001, 1'b0);
        tests_run++;
        if (bus8.grant !== 4'b0001 || bus8.grant_idx !== 2'd0 || bus8.grant_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_grant actual=%b/%b/%b required=0001/00/1", bus8.grant, bus8.grant_idx, bus8.grant_valid);
        end
        cycle(4'b0000, 1'b0);
        tests_run++;
        if (bus8.grant !== 4'b0000 || bus8.grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_release actual=%b/%b required=0000/0", bus8.grant, bus8.grant_valid);
        end
    endtask

    task automatic test_rotation();
        cycle(4'b0000, 1'b1);
        cycle(4'b1111, 1'b0);
        cycle(4'b1111, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] all;
            all = 4'b1111;
            cycle(all & ~(4'b0001 << k), 1'b0);
            tests_run++;
            if (bus8.grant !== 4'(1 << ((k + 1) % 4)) || bus8.grant_idx !== 2'((k + 1) % 4) || bus8.grant_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL rotation_step%0d actual=%b/%b required=%b/%0d", k, bus8.grant, bus8.grant_idx,
                         4'(1 << ((k + 1) % 4)), (k + 1) % 4);
            end
            cycle(4'b1111, 1'b0);
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_hold_limit();
        cycle(4'b0000, 1'b1);
        for (int c = 0; c < 40; c++) begin
            cycle(4'b0011, 1'b0);
            tests_run++;
            if (bus8.grant !== (((c / 8) % 2 == 0) ? 4'b0001 : 4'b0010)) begin
                tests_failed++;
                $display("FAIL hold_limit_c%0d actual=%b required=%b", c, bus8.grant,
                         ((c / 8) % 2 == 0) ? 4'b0001 : 4'b0010);
            end
            tests_run++;
            if (bus0.grant !== 4'b0001) begin
                tests_failed++;
                $display("FAIL hold_unlimited_c%0d actual=%b required=0001", c, bus0.grant);
            end
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_lone_holder();
        cycle(4'b0000, 1'b1);
        for (int c = 0; c < 20; c++) begin
            cycle(4'b0100, 1'b0);
            tests_run++;
            if (bus8.grant !== 4'b0100 || bus8.grant_idx !== 2'd2) begin
                tests_failed++;
                $display("FAIL lone_hold_c%0d actual=%b/%b required=0100/10", c, bus8.grant, bus8.grant_idx);
            end
        end
        cycle(4'b0101, 1'b0);
        tests_run++;
        if (bus8.grant !== 4'b0001 || bus8.grant_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL lone_preempt actual=%b/%b required=0001/00", bus8.grant, bus8.grant_idx);
        end
        tests_run++;
        if (bus0.grant !== 4'b0100) begin
            tests_failed++;
            $display("FAIL lone_no_limit actual=%b required=0100", bus0.grant);
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_ptr_after_idle();
        cycle(4'b0000, 1'b1);
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        tests_run++;
        if (bus8.grant !== 4'b0000 || bus8.grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ptr_idle actual=%b/%b required=0000/0", bus8.grant, bus8.grant_valid);
        end
        cycle(4'b1001, 1'b0);
        tests_run++;
        if (bus8.grant !== 4'b1000 || bus8.grant_idx !== 2'd3) begin
            tests_failed++;
            $display("FAIL ptr_scan actual=%b/%b required=1000/11", bus8.grant, bus8.grant_idx);
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        cycle(4'b0000, 1'b1);
        cycle(4'b0010, 1'b0);
        cycle(4'b1010, 1'b1);
        tests_run++;
        if (bus8.grant !== 4'b0000 || bus8.grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear actual=%b/%b required=0000/0", bus8.grant, bus8.grant_valid);
        end
        cycle(4'b1010, 1'b0);
        tests_run++;
        if (bus8.grant !== 4'b0010 || bus8.grant_idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL reset_mid_regrant actual=%b/%b required=0010/01", bus8.grant, bus8.grant_idx);
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            cycle(r, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m8           = '0;
        m0           = '0;
        rst          = 1'b1;
        bus8.req     = 4'b0000;
        bus0.req     = 4'b0000;
        test_reset();
        test_basic();
        test_rotation();
        test_hold_limit();
        test_lone_holder();
        test_ptr_after_idle();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
